cvt_int_fp_mod: RTL

- Pipelined integer-to-floating-point converter for the FPU low cluster; the inverse of the FP-to-integer convert path.
- Takes a 64-bit or 32-bit, signed or unsigned integer operand from the integer side.
- Produces a single, double or extended result in the 84-bit FUF register layout, with an inexact flag.
- Three-stage pipeline stalled by clkEn, matching the alt-enable stall of the FP cluster.

---
 rtl/fpoperations.sv | 60 ++++++
 rtl/cvt_lzc64.sv | 14 +
 rtl/cvt_int_fp_mod.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fpoperations.sv
// Shared FPU low-cluster definitions: result formats, rounding modes, per-format
// precision/bias constants, FUF field offsets and convert pipeline stage structs.
package fpoperations;

    typedef enum logic [1:0] {
        FMT_SNG = 2'd0,
        FMT_DBL = 2'd1,
        FMT_EXT = 2'd2
    } fmt_e;

    localparam logic [1:0] RND_RNE = 2'd0;
    localparam logic [1:0] RND_RTZ = 2'd1;
    localparam logic [1:0] RND_RDN = 2'd2;
    localparam logic [1:0] RND_RUP = 2'd3;

    localparam int SNG_PREC = 24;
    localparam int DBL_PREC = 53;
    localparam int EXT_PREC = 64;
    localparam int SNG_FRAC = SNG_PREC - 1;
    localparam int DBL_FRAC = DBL_PREC - 1;

    localparam logic [7:0]  SNG_BIAS = 8'd127;
    localparam logic [10:0] DBL_BIAS = 11'd1023;
    localparam logic [14:0] EXT_BIAS = 15'd16383;

    localparam int FUF_W      = 84;
    localparam int FUF_EXT_LO = 68;

    // Magnitude is kept in 64 bits: negating the most negative 64-bit value
    // yields 2^63, which is still exact as an unsigned quantity.
    typedef struct packed {
        logic        sign;
        logic [63:0] mag;
        fmt_e        fmt;
        logic [1:0]  rnd;
    } s1_t;

    typedef struct packed {
        logic        sign;
        logic        zero;
        logic [5:0]  exp;
        logic [63:0] norm;
        fmt_e        fmt;
        logic [1:0]  rnd;
    } s2_t;

    function automatic logic rnd_inc(input logic [1:0] rnd, input logic sign,
                                     input logic lsb, input logic guard,
                                     input logic sticky);
        logic inc;
        case (rnd)
            RND_RNE: inc = guard & (sticky | lsb);
            RND_RTZ: inc = 1'b0;
            RND_RDN: inc = sign & (guard | sticky);
            default: inc = ~sign & (guard | sticky);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/cvt_lzc64.sv
// Combinational 64-bit leading-zero counter; returns 64 for an all-zero input.
module cvt_lzc64 (
    input  logic [63:0] a,
    output logic [6:0]  cnt
);

    always_comb begin
        cnt = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (a[i]) cnt = 7'(63 - i);
        end
    end

endmodule

// File: rtl/cvt_int_fp_mod.sv
// Three-stage integer to SNG/DBL/EXT converter producing FUF-layout results;
// every stage register advances only when clkEn is high.
module cvt_int_fp_mod
    import fpoperations::*;
#(
    parameter int LAT    = 3,
    parameter bit EXT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              en,
    input  logic [63:0]       A,
    input  logic              is32b,
    input  logic              isSigned,
    input  logic              isSNG,
    input  logic              isDBL,
    input  logic              isEXT,
    input  logic [1:0]        rnd,
    output logic [FUF_W-1:0]  res,
    output logic              res_en,
    output logic              inexact
);

    logic [LAT-1:0]   vld_pipe;
    s1_t              s1, s1_d;
    s2_t              s2, s2_d;
    logic [63:0]      op;
    logic [6:0]       lzc;
    logic [FUF_W-1:0] res_d;
    logic             inx_d;
    logic             g, st, inc;
    logic [SNG_FRAC:0] sum_s;
    logic [DBL_FRAC:0] sum_d;
    logic [7:0]       e_s;
    logic [10:0]      e_d;
    logic [14:0]      e_x;

    assign res_en = vld_pipe[LAT-1];

    // Stage 1: operand extension, sign/magnitude split, format priority.
    always_comb begin
        op = A;
        if (is32b) op = isSigned ? {{32{A[31]}}, A[31:0]} : {32'b0, A[31:0]};
        s1_d.sign = isSigned & op[63];
        s1_d.mag  = s1_d.sign ? (~op + 64'd1) : op;
        if (isEXT && EXT_EN)     s1_d.fmt = FMT_EXT;
        else if (isDBL || isEXT) s1_d.fmt = FMT_DBL;
        else                     s1_d.fmt = FMT_SNG;
        s1_d.rnd = rnd;
    end

    // Stage 2: normalize so the leading one sits at bit 63.
    cvt_lzc64 u_lzc (
        .a   (s1.mag),
        .cnt (lzc)
    );

    always_comb begin
        s2_d.sign = s1.sign;
        s2_d.zero = lzc[6];
        s2_d.exp  = 6'd63 - lzc[5:0];
        s2_d.norm = s1.mag << lzc[5:0];
        s2_d.fmt  = s1.fmt;
        s2_d.rnd  = s1.rnd;
    end

    // Stage 3: round the fraction only; a carry out of it means the
    // significand wrapped to 1.0 and the exponent steps up by one.
    always_comb begin
        res_d = '0;
        inx_d = 1'b0;
        g     = 1'b0;
        st    = 1'b0;
        inc   = 1'b0;
        sum_s = '0;
        sum_d = '0;
        e_s   = '0;
        e_d   = '0;
        e_x   = '0;
        case (s2.fmt)
            FMT_EXT: begin
                e_x = EXT_BIAS + {9'b0, s2.exp};
                res_d[FUF_W-1:FUF_EXT_LO] = {s2.sign, e_x};
                res_d[EXT_PREC-1:0]       = s2.norm;
            end
            FMT_DBL: begin
                g     = s2.norm[63-DBL_PREC];
                st    = |s2.norm[63-DBL_PREC-1:0];
                inc   = rnd_inc(s2.rnd, s2.sign, s2.norm[64-DBL_PREC], g, st);
                sum_d = {1'b0, s2.norm[62 -: DBL_FRAC]} + {{DBL_FRAC{1'b0}}, inc};
                e_d   = DBL_BIAS + {5'b0, s2.exp} + {10'b0, sum_d[DBL_FRAC]};
                res_d[63:0] = {s2.sign, e_d, sum_d[DBL_FRAC-1:0]};
                inx_d = g | st;
            end
            default: begin
                g     = s2.norm[63-SNG_PREC];
                st    = |s2.norm[63-SNG_PREC-1:0];
                inc   = rnd_inc(s2.rnd, s2.sign, s2.norm[64-SNG_PREC], g, st);
                sum_s = {1'b0, s2.norm[62 -: SNG_FRAC]} + {{SNG_FRAC{1'b0}}, inc};
                e_s   = SNG_BIAS + {2'b0, s2.exp} + {7'b0, sum_s[SNG_FRAC]};
                res_d[31:0] = {s2.sign, e_s, sum_s[SNG_FRAC-1:0]};
                inx_d = g | st;
            end
        endcase
        if (s2.zero) begin
            res_d = '0;
            inx_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            s2       <= '0;
            res      <= '0;
            inexact  <= 1'b0;
        end else if (clkEn) begin
            vld_pipe <= {vld_pipe[LAT-2:0], en};
            s1       <= s1_d;
            s2       <= s2_d;
            if (vld_pipe[LAT-2]) begin
                res     <= res_d;
                inexact <= inx_d;
            end
        end
    end

endmodule
